// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one fetched instruction with its PC and PC+4 link value
//   FETCH_NOP_INSTR : value shown on the instruction output when nothing is live
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_DATA_W-1:0] FETCH_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_ADDR_W-1:0] pcPlus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
//   Single-entry parking slot for an instruction accepted from memory while
//   the decode-facing output register is still occupied and stalled.
//   Ports:
//     clk_i    : clock
//     rst_ni   : asynchronous active-low reset
//     clear_i  : discard the parked entry (highest priority)
//     load_i   : park entry_i
//     drain_i  : entry has been moved out, mark slot empty
//     entry_i  : entry to park
//     entry_o  : parked entry
//     valid_o  : slot holds a live entry
// ----------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   load_i,
    input  logic   drain_i,
    input  entry_t entry_i,
    output entry_t entry_o,
    output logic   valid_o
);

    entry_t entry_q, entry_d;
    logic   valid_q, valid_d;

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            entry_d = entry_i;
            valid_d = 1'b1;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign entry_o = entry_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage between the PC block and decode. Latches the current PC,
//   issues one variable-latency read to instruction memory, and presents
//   {instruction, PC, PC+4} to decode through a valid/stall interface.
//   The PC block advances exactly once per instruction accepted from memory.
//   A flush discards in-flight and buffered instructions.
//   Ports:
//     clk                : clock, all state on rising edge
//     rst                : asynchronous active-low reset
//     pcAddress          : current PC from the PC block
//     nextPCAddress      : PC+4 from the PC block
//     count              : PC advance enable, one-cycle pulse on acceptance
//     memRead            : read request, held until memReady
//     memAddress         : registered request address
//     memReady           : read data valid this cycle
//     memData            : read data
//     decodeStall        : decode is not consuming the output this cycle
//     flush              : branch/jump taken; PC loads its new value this cycle
//     instruction        : instruction to decode (NOP_INSTR when not valid)
//     instructionPC      : address of the instruction
//     instructionPCPlus4 : its PC+4 link value
//     instructionValid   : outputs hold a live instruction
// ----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = FETCH_ADDR_W,
    parameter int unsigned           DATA_WIDTH = FETCH_DATA_W,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = FETCH_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcAddress,
    input  logic [ADDR_WIDTH-1:0] nextPCAddress,
    output logic                  count,
    output logic                  memRead,
    output logic [ADDR_WIDTH-1:0] memAddress,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  decodeStall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instructionPC,
    output logic [ADDR_WIDTH-1:0] instructionPCPlus4,
    output logic                  instructionValid
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pcPlus4;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] memAddress_q, memAddress_d;
    logic [ADDR_WIDTH-1:0] reqPC_q, reqPC_d;
    logic [ADDR_WIDTH-1:0] reqPCPlus4_q, reqPCPlus4_d;
    logic                  dropPending_q, dropPending_d;
    entry_t                out_q, out_d;
    logic                  outValid_q, outValid_d;

    entry_t fetched;
    entry_t out_src;
    logic   out_load;
    logic   out_free;
    logic   buf_load, buf_drain, buf_clear, buf_valid;
    entry_t buf_entry;

    always_comb begin
        fetched.instr   = memData;
        fetched.pc      = reqPC_q;
        fetched.pcPlus4 = reqPCPlus4_q;
    end

    // Output register can take a new entry if it is empty or being consumed.
    assign out_free = !outValid_q || !decodeStall;

    // ------------------------------------------------------------------
    // FSM next state, request registers and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        memAddress_d  = memAddress_q;
        reqPC_d       = reqPC_q;
        reqPCPlus4_d  = reqPCPlus4_q;
        dropPending_d = dropPending_q;
        memRead       = 1'b0;
        count         = 1'b0;
        out_load      = 1'b0;
        out_src       = fetched;
        buf_load      = 1'b0;
        buf_drain     = 1'b0;
        buf_clear     = flush;

        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
            end

            FS_REQ: begin
                memAddress_d = pcAddress;
                reqPC_d      = pcAddress;
                reqPCPlus4_d = nextPCAddress;
                // On flush the PC is loading its target this cycle; relatch next cycle.
                state_d      = flush ? FS_REQ : FS_WAIT;
            end

            FS_WAIT: begin
                memRead = 1'b1;
                if (memReady) begin
                    if (dropPending_q || flush) begin
                        dropPending_d = 1'b0;
                        state_d       = FS_REQ;
                    end else if (out_free) begin
                        count    = 1'b1;
                        out_load = 1'b1;
                        state_d  = FS_REQ;
                    end else begin
                        count    = 1'b1;
                        buf_load = 1'b1;
                        state_d  = FS_HOLD;
                    end
                end else if (flush) begin
                    // The memory transaction must complete; remember to discard it.
                    dropPending_d = 1'b1;
                end
            end

            FS_HOLD: begin
                if (flush) begin
                    state_d = FS_REQ;
                end else if (!decodeStall) begin
                    buf_drain = 1'b1;
                    out_load  = buf_valid;
                    out_src   = buf_entry;
                    state_d   = FS_REQ;
                end
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode-facing output register
    // ------------------------------------------------------------------
    always_comb begin
        out_d      = out_q;
        outValid_d = outValid_q;
        if (flush) begin
            outValid_d  = 1'b0;
            out_d.instr = NOP_INSTR;
        end else if (out_load) begin
            out_d      = out_src;
            outValid_d = 1'b1;
        end else if (outValid_q && !decodeStall) begin
            outValid_d  = 1'b0;
            out_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FS_IDLE;
            memAddress_q  <= '0;
            reqPC_q       <= '0;
            reqPCPlus4_q  <= '0;
            dropPending_q <= 1'b0;
            out_q         <= '{instr: NOP_INSTR, pc: '0, pcPlus4: '0};
            outValid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            memAddress_q  <= memAddress_d;
            reqPC_q       <= reqPC_d;
            reqPCPlus4_q  <= reqPCPlus4_d;
            dropPending_q <= dropPending_d;
            out_q         <= out_d;
            outValid_q    <= outValid_d;
        end
    end

    fetch_skid_buffer #(
        .entry_t (entry_t)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (buf_clear),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .entry_i (fetched),
        .entry_o (buf_entry),
        .valid_o (buf_valid)
    );

    assign memAddress         = memAddress_q;
    assign instruction        = out_q.instr;
    assign instructionPC      = out_q.pc;
    assign instructionPCPlus4 = out_q.pcPlus4;
    assign instructionValid   = outValid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Bench with a behavioural PC block, an instruction memory with
//   programmable wait states, and an in-order scoreboard of the program
//   stream decode should see: consecutive PCs from the reset vector,
//   restarting at the target whenever a flush is taken.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] pcAddress, nextPCAddress;
    logic        count, memRead, memReady, decodeStall, flush, instructionValid;
    logic [31:0] memAddress, memData, instruction, instructionPC, instructionPCPlus4;
    logic [31:0] newPC;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // stimulus controls
    bit          stall_cmd, flush_cmd, flush_on_ready, rand_wait, inject;
    int unsigned fixed_wait;

    // scoreboard / statistics
    logic [31:0] exp_pc;
    int unsigned cyc, pulses, consumed, flush_cnt;
    int          first_valid;
    int unsigned cons_cyc[8];

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pcAddress          (pcAddress),
        .nextPCAddress      (nextPCAddress),
        .count              (count),
        .memRead            (memRead),
        .memAddress         (memAddress),
        .memReady           (memReady),
        .memData            (memData),
        .decodeStall        (decodeStall),
        .flush              (flush),
        .instruction        (instruction),
        .instructionPC      (instructionPC),
        .instructionPCPlus4 (instructionPCPlus4),
        .instructionValid   (instructionValid)
    );

    // PC block
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc_q <= RESET_PC;
        else if (flush) pc_q <= newPC;
        else if (count) pc_q <= pc_q + 32'd4;
    end
    assign pcAddress     = pc_q;
    assign nextPCAddress = pc_q + 32'd4;

    // Instruction memory: answers after wait_cur cycles of memRead high.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    int unsigned busy_cnt, wait_cur;
    assign memReady = (memRead && busy_cnt == wait_cur) || inject;
    assign memData  = memReady ? mem_word(memAddress) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 0;
            wait_cur <= rand_wait ? $urandom_range(0, 3) : fixed_wait;
        end else if (!memRead || memReady) begin
            busy_cnt <= 0;
            if (memReady) wait_cur <= rand_wait ? $urandom_range(0, 3) : fixed_wait;
        end else begin
            busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic clear_stats();
        exp_pc      = RESET_PC;
        cyc         = 0;
        pulses      = 0;
        consumed    = 0;
        flush_cnt   = 0;
        first_valid = -1;
    endtask

    // Called and returns on a falling edge.
    task automatic do_reset(input int unsigned w);
        fixed_wait = w;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_stats();
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, score what the
    // next rising edge will act on, advance to the next falling edge.
    task automatic step();
        decodeStall = stall_cmd;
        flush       = flush_cmd || (flush_on_ready && memReady);
        #1;
        if (instructionValid && first_valid < 0) first_valid = int'(cyc);
        if (instructionValid && !decodeStall) begin
            check_eq("dec_pc", instructionPC, exp_pc);
            check_eq("dec_instr", instruction, mem_word(exp_pc));
            check_eq("dec_pc4", instructionPCPlus4, exp_pc + 32'd4);
            if (consumed < 8) cons_cyc[consumed] = cyc;
            consumed++;
            exp_pc = exp_pc + 32'd4;
        end
        if (!instructionValid) check_eq("nop_idle", instruction, NOP);
        if (flush) begin
            check_eq("count_in_flush", 32'(count), 32'd0);
            exp_pc = newPC;
            flush_cnt++;
        end
        if (count) pulses++;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned hi, p0, fc0;
        rst = 1'b0;
        stall_cmd = 0; flush_cmd = 0; flush_on_ready = 0; rand_wait = 0; inject = 0;
        fixed_wait = 0; newPC = RESET_PC; decodeStall = 1'b0; flush = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_memRead", 32'(memRead), 32'd0);
        check_eq("rst_memAddr", memAddress, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(instructionValid), 32'd0);
        check_eq("rst_instr", instruction, NOP);
        check_eq("rst_pc", instructionPC, 32'd0);
        check_eq("rst_pc4", instructionPCPlus4, 32'd0);

        // 1: zero-wait memory, no stall
        do_reset(0);
        for (int n = 0; n < 20 && consumed < 3; n++) step();
        check_eq("t1_consumed", consumed, 32'd3);
        check_eq("t1_latency", first_valid, 32'd3);
        check_eq("t1_pulses", pulses, 32'd3);
        check_eq("t1_throughput", cons_cyc[2] - cons_cyc[0], 32'd4);

        // 2: three wait states
        do_reset(3);
        hi = 0;
        for (int n = 0; n < 20 && pulses == 0; n++) begin
            if (memRead) begin
                hi++;
                check_eq("t2_addr", memAddress, RESET_PC);
            end
            step();
        end
        check_eq("t2_read_cycles", hi, 32'd4);
        check_eq("t2_pulses", pulses, 32'd1);
        check_eq("t2_read_drop", 32'(memRead), 32'd0);
        for (int n = 0; n < 20 && consumed < 1; n++) step();
        check_eq("t2_consumed", consumed, 32'd1);

        // 3: decode stalls for 6 cycles after the first valid instruction
        do_reset(0);
        for (int n = 0; n < 20 && !instructionValid; n++) step();
        stall_cmd = 1;
        p0 = pulses;
        for (int n = 0; n < 6; n++) begin
            check_eq("t3_frozen_pc", instructionPC, RESET_PC);
            check_eq("t3_frozen_valid", 32'(instructionValid), 32'd1);
            step();
        end
        check_eq("t3_hold_no_read", 32'(memRead), 32'd0);
        check_eq("t3_one_parked", pulses - p0, 32'd1);
        stall_cmd = 0;
        for (int n = 0; n < 30 && consumed < 3; n++) step();
        check_eq("t3_consumed", consumed, 32'd3);

        // 4: flush while waiting on memory
        do_reset(3);
        for (int n = 0; n < 20 && !memRead; n++) step();
        step();
        newPC = 32'h0040_0100;
        flush_cmd = 1;
        step();
        flush_cmd = 0;
        p0 = pulses;
        for (int n = 0; n < 40 && consumed < 1; n++) step();
        check_eq("t4_consumed", consumed, 32'd1);
        check_eq("t4_pulses", pulses - p0, 32'd1);

        // 5a: flush together with memReady while the output is stalled
        do_reset(0);
        stall_cmd = 1;
        for (int n = 0; n < 20 && !instructionValid; n++) step();
        newPC = 32'h0040_0200;
        flush_on_ready = 1;
        fc0 = flush_cnt;
        p0 = pulses;
        for (int n = 0; n < 10 && flush_cnt == fc0; n++) step();
        flush_on_ready = 0;
        check_eq("t5a_valid", 32'(instructionValid), 32'd0);
        check_eq("t5a_instr", instruction, NOP);
        check_eq("t5a_no_count", pulses - p0, 32'd0);
        // 5b: flush while an instruction is parked
        for (int n = 0; n < 20 && !instructionValid; n++) step();
        step();
        step();
        check_eq("t5b_hold_read", 32'(memRead), 32'd0);
        check_eq("t5b_hold_valid", 32'(instructionValid), 32'd1);
        newPC = 32'h0040_0300;
        flush_cmd = 1;
        p0 = pulses;
        step();
        flush_cmd = 0;
        check_eq("t5b_valid", 32'(instructionValid), 32'd0);
        check_eq("t5b_instr", instruction, NOP);
        check_eq("t5b_no_count", pulses - p0, 32'd0);
        stall_cmd = 0;
        for (int n = 0; n < 30 && consumed < 2; n++) step();
        check_eq("t5b_consumed", consumed, 32'd2);

        // 6: reset asserted mid-WAIT, late memReady while idle
        do_reset(3);
        for (int n = 0; n < 20 && !memRead; n++) step();
        step();
        rst = 1'b0;
        #1;
        check_eq("t6_memRead", 32'(memRead), 32'd0);
        check_eq("t6_memAddr", memAddress, 32'd0);
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_valid", 32'(instructionValid), 32'd0);
        check_eq("t6_instr", instruction, NOP);
        check_eq("t6_pc", instructionPC, 32'd0);
        check_eq("t6_pc4", instructionPCPlus4, 32'd0);
        @(negedge clk);
        clear_stats();
        rst = 1'b1;
        inject = 1;
        step();
        inject = 0;
        check_eq("t6_ignored_ready", pulses, 32'd0);
        for (int n = 0; n < 40 && consumed < 1; n++) step();
        check_eq("t6_consumed", consumed, 32'd1);
        check_eq("t6_pulses", pulses, 32'd1);

        // Randomized stall / flush / memory latency
        rand_wait = 1;
        do_reset(0);
        for (int n = 0; n < 2000; n++) begin
            stall_cmd = ($urandom_range(0, 99) < 30);
            flush_cmd = ($urandom_range(0, 99) < 3);
            if (flush_cmd) newPC = RESET_PC + ($urandom_range(0, 255) << 2);
            step();
        end
        flush_cmd = 0;
        stall_cmd = 0;
        check_eq("rand_progress", 32'(consumed >= 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
